clk_period_checker: RTL and testbench
=====================================

# clk_period_checker

Synthesizable clock-period checker: measures the period of an asynchronous monitored signal (`mon_in`, typically a divided or foreign clock) in cycles of the system clock `clk`, over `NUM_PERIODS` consecutive periods. Each period is compared against a programmed expected value and tolerance, and the block reports pass/fail/timeout through a start/done handshake. It is the on-chip counterpart of our simulation clock-period assertions, and is sequenced by test/bring-up firmware or a BIST controller.

## Interface
- `CNT_W`, 16: width of the period counter and of all period/limit fields.
- `NUM_PERIODS`, 4: consecutive periods measured per run (≥1).
- `SYNC_STAGES`, 2: synchronizer flops on `mon_in` (≥2).
- Clock and reset: one clock, `clk`; reset `rst_n`, asynchronous, active-low.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mon_in` in 1: monitored signal, asynchronous to `clk`.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `exp_period` in CNT_W: expected period in `clk` cycles; sampled at start.
- `tol` in CNT_W: allowed absolute deviation; sampled at start.
- `timeout_lim` in CNT_W: maximum cycles to wait for any edge; sampled at start.
- `busy` out 1: high from the cycle after start is accepted until DONE.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass` out 1: 1 if no period failed and no timeout occurred.
- `timeout` out 1: run aborted on a missing edge.
- `last_period` out CNT_W: most recent measured period.
- `fail_cnt` out 8: periods out of tolerance this run; saturates at 255.

## Operation
- `mon_in` passes through SYNC_STAGES flops, then one delay flop. `rise` = sync_out & ~delayed.
- Period is defined as t1 − t0, where t0 and t1 are the cycles of consecutive `rise` pulses.
- Counter: on `rise` it loads 1, otherwise it increments and saturates at all-ones. It also loads 1 on start acceptance, which makes it the timeout counter in SYNC.
- FSM states:
  - IDLE: `start` captures `exp_period`, `tol` and `timeout_lim`, clears `fail_cnt`, `pass`, `timeout` and the period index, then goes to SYNC.
  - SYNC: discards everything up to the first `rise`. On `rise`, go to MEASURE; the first partial period is never checked.
  - MEASURE: on `rise`, capture the counter into `last_period` and check it. Increment the index. When index = NUM_PERIODS, go to DONE.
  - DONE: lasts one cycle, drives `done`=1, then returns to IDLE.
- Check: |period − exp| ≤ tol, computed in CNT_W+1 bits with no wrap. A failing period increments `fail_cnt`.
- Timeout: in SYNC or MEASURE, if counter = `timeout_lim` and there is no `rise` that cycle, set `timeout`=1 and go to DONE. A `rise` in the same cycle as the limit wins (no timeout).
- `pass` is set in the DONE cycle: (`fail_cnt`==0) & ~`timeout`.
- `start` is ignored in SYNC, MEASURE and DONE.
- Changes to `exp_period`, `tol` and `timeout_lim` during a run have no effect.

## Timing
- Reset values: `busy`, `done`, `pass`, `timeout` = 0; `last_period` = 0; `fail_cnt` = 0; FSM in IDLE; synchronizer flops = 0.
- `rst_n` low mid-run aborts immediately to the reset state. No `done` pulse is produced.
- `rise` asserts SYNC_STAGES+1 cycles after a `mon_in` rising edge that meets setup.
- `busy` rises the cycle after `start` is accepted.
- `last_period` and `fail_cnt` update the cycle after the corresponding `rise`.
- `done` pulses one cycle after the final capture (or after the timeout cycle). `busy` is 0 in that same cycle.
- `pass`, `timeout`, `last_period` and `fail_cnt` hold from DONE until the next accepted `start`.
- `mon_in` high or low phases shorter than 2 `clk` cycles are unsupported. The result is undefined but the FSM must not lock up.

## Test plan
- Nominal: `mon_in` toggles every 18 clk (period 36), exp=36, tol=0, NUM_PERIODS=4 -> `done` pulse, `pass`=1, `last_period`=36, `fail_cnt`=0, `timeout`=0.
- Wrong expectation: same stimulus, exp=18, tol=0 -> `pass`=0, `fail_cnt`=4, `last_period`=36.
- Tolerance boundary: period 38, exp=36 -> with tol=2, `pass`=1; with tol=1, `pass`=0 and `fail_cnt`=4. Also period 34 with tol=2 -> `pass`=1 (checks the underflow side).
- Timeout: `mon_in` held at 0, `timeout_lim`=100 -> `done` about 100 cycles after start, `timeout`=1, `pass`=0. Also stop `mon_in` after 2 good periods -> `timeout`=1, `last_period`=36.
- Handshake: pulse `start` while `busy`, and in the DONE cycle -> ignored, run result unchanged. A `start` one cycle after `done` -> accepted, outputs cleared.
- Reset mid-run: assert `rst_n` low during MEASURE -> all outputs return to 0 asynchronously, no `done` pulse. A new `start` after release completes normally with `pass`=1.

Source files
------------

// File: rtl/clk_period_checker.sv
// Clock-period checker: measures NUM_PERIODS periods of an asynchronous
// monitored signal in clk cycles and checks them against exp_period +/- tol.
module clk_period_checker #(
    parameter int CNT_W       = 16,
    parameter int NUM_PERIODS = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_in,
    input  logic             start,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] tol,
    input  logic [CNT_W-1:0] timeout_lim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] last_period,
    output logic [7:0]       fail_cnt
);

    typedef enum logic [1:0] {IDLE, SYNC, MEASURE, DONE} state_t;

    localparam int IDX_W = $clog2(NUM_PERIODS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PERIODS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state, nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       exp_q;
    logic [CNT_W-1:0]       tol_q;
    logic [CNT_W-1:0]       lim_q;
    logic [IDX_W-1:0]       idx;
    logic                   accept;
    logic                   cap;
    logic                   to_hit;
    logic                   bad;
    logic [CNT_W:0]         diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

    // Period counter doubles as the edge-wait timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise || accept) begin
            cnt <= CNT_ONE;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_comb begin
        if (cnt >= exp_q) diff = {1'b0, cnt} - {1'b0, exp_q};
        else              diff = {1'b0, exp_q} - {1'b0, cnt};
        bad = diff > {1'b0, tol_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        cap    = 1'b0;
        to_hit = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    nxt    = SYNC;
                end
            end
            SYNC: begin
                busy = 1'b1;
                if (rise) begin
                    nxt = MEASURE;
                end else if (cnt == lim_q) begin
                    to_hit = 1'b1;
                    nxt    = DONE;
                end
            end
            MEASURE: begin
                busy = 1'b1;
                if (rise) begin
                    cap = 1'b1;
                    if (idx == LAST_IDX) nxt = DONE;
                end else if (cnt == lim_q) begin
                    to_hit = 1'b1;
                    nxt    = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q       <= '0;
            tol_q       <= '0;
            lim_q       <= '0;
            idx         <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            last_period <= '0;
            fail_cnt    <= '0;
        end else begin
            if (accept) begin
                exp_q    <= exp_period;
                tol_q    <= tol;
                lim_q    <= timeout_lim;
                idx      <= '0;
                pass     <= 1'b0;
                timeout  <= 1'b0;
                fail_cnt <= '0;
            end
            if (cap) begin
                last_period <= cnt;
                idx         <= idx + IDX_W'(1);
                if (bad && fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
                // Final capture: fold in this period's verdict too.
                if (idx == LAST_IDX) pass <= (fail_cnt == 8'd0) && !bad;
            end
            if (to_hit) begin
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_checker.sv
// Self-checking bench for clk_period_checker: directed scenarios plus
// randomized per-period lengths checked against an arithmetic model.
module tb_clk_period_checker;

    localparam int CW = 16;
    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mon_in = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] exp_period = '0;
    logic [CW-1:0] tol = '0;
    logic [CW-1:0] timeout_lim = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [CW-1:0] last_period;
    logic [7:0]    fail_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int qhi[$];
    int qlo[$];

    clk_period_checker #(.CNT_W(CW), .NUM_PERIODS(NP), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mon_in(mon_in), .start(start),
        .exp_period(exp_period), .tol(tol), .timeout_lim(timeout_lim),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .last_period(last_period), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_periods(input int hi, input int lo, input int n);
        qhi.delete();
        qlo.delete();
        for (int i = 0; i < n; i++) begin
            qhi.push_back(hi);
            qlo.push_back(lo);
        end
    endtask

    task automatic prep();
        @(negedge clk);
        mon_in = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Inputs are scrambled right after acceptance; they must not matter.
    task automatic pulse_start(input int e, input int t, input int l);
        @(negedge clk);
        exp_period = CW'(e);
        tol = CW'(t);
        timeout_lim = CW'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_period = CW'($urandom);
        tol = CW'($urandom);
        timeout_lim = CW'($urandom_range(1, 8));
    endtask

    task automatic drive_mon();
        for (int i = 0; i < qhi.size(); i++) begin
            mon_in = 1'b1;
            repeat (qhi[i]) @(negedge clk);
            mon_in = 1'b0;
            repeat (qlo[i]) @(negedge clk);
        end
        mon_in = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic run_case(input int e, input int t, input int l, output bit got);
        int cyc;
        prep();
        pulse_start(e, t, l);
        fork
            drive_mon();
            wait_done(3000, cyc, got);
        join
    endtask

    function automatic int model_fails(input int e, input int t);
        int f = 0;
        for (int i = 0; i < NP; i++) begin
            int p = qhi[i] + qlo[i];
            int d = (p > e) ? p - e : e - p;
            if (d > t) f++;
        end
        return f;
    endfunction

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, done, pass, timeout, last_period, fail_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b", {busy, done, pass, timeout, last_period, fail_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        bit got;
        int cyc;
        set_periods(18, 18, NP);
        prep();
        pulse_start(36, 0, 1000);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_busy: got %b want 1", busy);
        end
        fork
            drive_mon();
            wait_done(3000, cyc, got);
        join
        n_checks++;
        if (!got || pass !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_flags: done %b pass %b timeout %b busy %b want 1 1 0 0",
                     got, pass, timeout, busy);
        end
        n_checks++;
        if (last_period !== 16'd36 || fail_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL nominal_vals: last %0d fails %0d want 36 0", last_period, fail_cnt);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_hold: done %b pass %b want 0 1", done, pass);
        end
    endtask

    task automatic test_wrong_exp();
        bit got;
        set_periods(18, 18, NP);
        run_case(18, 0, 1000, got);
        n_checks++;
        if (!got || pass !== 1'b0 || fail_cnt !== 8'd4 || last_period !== 16'd36) begin
            n_fail++;
            $display("FAIL wrong_exp: done %b pass %b fails %0d last %0d want 1 0 4 36",
                     got, pass, fail_cnt, last_period);
        end
    endtask

    task automatic test_tolerance();
        bit got;
        set_periods(19, 19, NP);
        run_case(36, 2, 1000, got);
        n_checks++;
        if (!got || pass !== 1'b1 || fail_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL tol_hi_in: done %b pass %b fails %0d want 1 1 0", got, pass, fail_cnt);
        end
        run_case(36, 1, 1000, got);
        n_checks++;
        if (!got || pass !== 1'b0 || fail_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL tol_hi_out: done %b pass %b fails %0d want 1 0 4", got, pass, fail_cnt);
        end
        set_periods(17, 17, NP);
        run_case(36, 2, 1000, got);
        n_checks++;
        if (!got || pass !== 1'b1 || last_period !== 16'd34) begin
            n_fail++;
            $display("FAIL tol_lo_in: done %b pass %b last %0d want 1 1 34", got, pass, last_period);
        end
        run_case(36, 1, 1000, got);
        n_checks++;
        if (!got || pass !== 1'b0 || fail_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL tol_lo_out: done %b pass %b fails %0d want 1 0 4", got, pass, fail_cnt);
        end
    endtask

    task automatic test_timeout();
        bit got;
        int cyc;
        prep();
        pulse_start(36, 0, 100);
        wait_done(400, cyc, got);
        n_checks++;
        if (!got || cyc < 100 || cyc > 102) begin
            n_fail++;
            $display("FAIL timeout_lat: done %b cycles %0d want 1 and 100..102", got, cyc);
        end
        n_checks++;
        if (timeout !== 1'b1 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flags: timeout %b pass %b want 1 0", timeout, pass);
        end
        set_periods(18, 18, 2);
        run_case(36, 0, 100, got);
        n_checks++;
        if (!got || timeout !== 1'b1 || pass !== 1'b0 || last_period !== 16'd36
            || fail_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL timeout_mid: done %b to %b pass %b last %0d fails %0d want 1 1 0 36 0",
                     got, timeout, pass, last_period, fail_cnt);
        end
    endtask

    task automatic test_handshake();
        bit got;
        int cyc;
        set_periods(18, 18, NP);
        prep();
        pulse_start(36, 0, 1000);
        fork
            drive_mon();
            begin
                repeat (60) @(negedge clk);
                exp_period = 16'd18;
                timeout_lim = 16'd3;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(3000, cyc, got);
        join
        n_checks++;
        if (!got || pass !== 1'b1 || fail_cnt !== 8'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_busy_start: done %b pass %b fails %0d to %b want 1 1 0 0",
                     got, pass, fail_cnt, timeout);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_done_start: busy %b pass %b want 0 1", busy, pass);
        end
        exp_period = 16'd99;
        timeout_lim = 16'd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || pass !== 1'b0 || fail_cnt !== 8'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_restart: busy %b pass %b fails %0d to %b want 1 0 0 0",
                     busy, pass, fail_cnt, timeout);
        end
        wait_done(200, cyc, got);
        n_checks++;
        if (!got || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_restart_end: done %b timeout %b want 1 1", got, timeout);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int cyc;
        bit saw_done = 1'b0;
        set_periods(18, 18, NP);
        prep();
        pulse_start(36, 0, 1000);
        fork
            drive_mon();
            begin
                repeat (60) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({busy, done, pass, timeout, last_period, fail_cnt} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_async: got %b",
                             {busy, done, pass, timeout, last_period, fail_cnt});
                end
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if (done) saw_done = 1'b1;
                end
                @(negedge clk);
                rst_n = 1'b1;
                repeat (120) begin
                    @(posedge clk);
                    #1;
                    if (done) saw_done = 1'b1;
                end
            end
        join
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_done: saw done %b want 0", saw_done);
        end
        run_case(36, 0, 1000, got);
        n_checks++;
        if (!got || pass !== 1'b1 || last_period !== 16'd36) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: done %b pass %b last %0d want 1 1 36",
                     got, pass, last_period);
        end
    endtask

    task automatic test_random();
        bit got;
        for (int r = 0; r < 8; r++) begin
            int e;
            int t;
            int ef;
            qhi.delete();
            qlo.delete();
            for (int i = 0; i < NP; i++) begin
                qhi.push_back($urandom_range(2, 25));
                qlo.push_back($urandom_range(2, 25));
            end
            e = qhi[0] + qlo[0] + $urandom_range(0, 6) - 3;
            t = $urandom_range(0, 6);
            ef = model_fails(e, t);
            run_case(e, t, 1000, got);
            n_checks++;
            if (!got || fail_cnt !== ef[7:0] || pass !== (ef == 0)
                || timeout !== 1'b0 || last_period !== CW'(qhi[NP-1] + qlo[NP-1])) begin
                n_fail++;
                $display("FAIL random_%0d: done %b fails %0d/%0d pass %b to %b last %0d/%0d",
                         r, got, fail_cnt, ef, pass, timeout, last_period,
                         qhi[NP-1] + qlo[NP-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrong_exp();
        test_tolerance();
        test_timeout();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
